// File: rtl/fib_bcd_converter.sv
// fib_bcd_converter: sequential double-dabble binary-to-BCD converter.
// Converts the Fibonacci datapath result one bit per clock.
//
// Ports:
//   clk        rising-edge system clock
//   usr_reset  synchronous active-high reset
//   start      request conversion of bin_in (honoured only when idle)
//   bin_in     binary value, captured on the accepting edge
//   busy       high while a conversion or its done cycle is in flight
//   done       one-cycle pulse, bcd_out valid from this cycle
//   bcd_out    packed BCD, digit 0 (units) in bits [3:0]
module fib_bcd_converter #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  usr_reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam longint unsigned MAX_BCD = 64'd10 ** DIGITS;
    localparam longint unsigned MAX_BIN = (64'd1 << DATA_W) - 64'd1;

    generate
        if (MAX_BCD <= MAX_BIN) begin : g_bad_digits
            $error("DIGITS too small to hold 2^DATA_W-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [SR_W-1:0]    sr_adj, sr_shift;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Add-3 on every BCD nibble that is >= 5, judged on the
    // pre-shift value; the shift then doubles it past 9 correctly.
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr_q[DATA_W+4*i +: 4] >= 4'd5) begin
                sr_adj[DATA_W+4*i +: 4] =
                    sr_q[DATA_W+4*i +: 4] + 4'd3;
            end
        end
        sr_shift = {sr_adj[SR_W-2:0], 1'b0};
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = {{BCD_W{1'b0}}, bin_in};
                    cnt_d   = CNT_W'(DATA_W);
                    state_d = CONV;
                end
            end
            CONV: begin
                sr_d  = sr_shift;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = sr_shift[SR_W-1 -: BCD_W];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Flags are decoded from the next state so they
        // come straight out of flops.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (usr_reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;

endmodule
